// File: rtl/carry_lookahead_subtractor_16bit_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - bin with borrow, overflow
// and zero flags, valid/ready handshakes on both sides.
// Stage 1 resolves the low LO_W bits and the carry into bit LO_W; stage 2
// resolves the upper bits from that registered carry, so no single cycle
// carries a full-width borrow chain.

// Parallel-prefix (Kogge-Stone) carry resolution over an N-bit slice.
module carry_lookahead_subtractor_16bit_pipe_cla #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] p_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int unsigned LVL = $clog2(N);

  logic [N-1:0] grp_g;
  logic [N-1:0] grp_p;
  logic [N:0]   carry;

  // Prefix tree: grp_g[i] is the carry out of bit i including cin_i.
  always_comb begin
    logic [N-1:0] g_nxt;
    logic [N-1:0] p_nxt;
    grp_g    = g_i;
    grp_p    = p_i;
    grp_g[0] = g_i[0] | (p_i[0] & cin_i);
    for (int lv = 0; lv < int'(LVL); lv++) begin
      g_nxt = grp_g;
      p_nxt = grp_p;
      for (int i = (1 << lv); i < int'(N); i++) begin
        g_nxt[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lv)]);
        p_nxt[i] = grp_p[i] & grp_p[i - (1 << lv)];
      end
      grp_g = g_nxt;
      grp_p = p_nxt;
    end
  end

  assign carry  = {grp_g, cin_i};
  assign sum_o  = p_i ^ carry[N-1:0];
  assign cout_o = carry[N];

endmodule

module carry_lookahead_subtractor_16bit_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  // Stage 1 payload
  logic [LO_W-1:0] s1_dlo_q, s1_dlo_d;
  logic            s1_c_q, s1_c_d;
  logic [HI_W-1:0] s1_ahi_q, s1_ahi_d;
  logic [HI_W-1:0] s1_bhi_q, s1_bhi_d;

  // Stage 2 payload (the visible outputs)
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Slice lookahead terms
  logic [LO_W-1:0] lo_g, lo_p, lo_sum;
  logic            lo_cout;
  logic [HI_W-1:0] hi_g, hi_p, hi_sum;
  logic            hi_cout;

  // Handshake: s2 can take a beat when empty or being drained this cycle.
  always_comb begin
    s2_free  = ~s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_free;
    in_ready = ~s1_valid_q | s1_adv;
    in_fire  = in_valid & in_ready;
  end

  // Valid-bit next state: refill wins over drain.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Valid-bit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 lookahead: subtract as a + ~b with carry-in ~bin.
  always_comb begin
    lo_g = a[LO_W-1:0] & ~b[LO_W-1:0];
    lo_p = a[LO_W-1:0] ^ ~b[LO_W-1:0];
  end

  carry_lookahead_subtractor_16bit_pipe_cla #(
    .N (LO_W)
  ) u_cla_lo (
    .g_i    (lo_g),
    .p_i    (lo_p),
    .cin_i  (~bin),
    .sum_o  (lo_sum),
    .cout_o (lo_cout)
  );

  // Stage 1 next payload
  always_comb begin
    s1_dlo_d = lo_sum;
    s1_c_d   = lo_cout;
    s1_ahi_d = a[WIDTH-1:LO_W];
    s1_bhi_d = b[WIDTH-1:LO_W];
  end

  // Stage 1 payload registers, loaded only on input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dlo_q <= '0;
      s1_c_q   <= 1'b0;
      s1_ahi_q <= '0;
      s1_bhi_q <= '0;
    end else if (in_fire) begin
      s1_dlo_q <= s1_dlo_d;
      s1_c_q   <= s1_c_d;
      s1_ahi_q <= s1_ahi_d;
      s1_bhi_q <= s1_bhi_d;
    end
  end

  // Stage 2 lookahead over the upper slice from the registered carry.
  always_comb begin
    hi_g = s1_ahi_q & ~s1_bhi_q;
    hi_p = s1_ahi_q ^ ~s1_bhi_q;
  end

  carry_lookahead_subtractor_16bit_pipe_cla #(
    .N (HI_W)
  ) u_cla_hi (
    .g_i    (hi_g),
    .p_i    (hi_p),
    .cin_i  (s1_c_q),
    .sum_o  (hi_sum),
    .cout_o (hi_cout)
  );

  // Stage 2 next payload: full result and flags
  always_comb begin
    diff_d = {hi_sum, s1_dlo_q};
    bout_d = ~hi_cout;
    ovf_d  = (s1_ahi_q[HI_W-1] ^ s1_bhi_q[HI_W-1]) &
             (hi_sum[HI_W-1] ^ s1_ahi_q[HI_W-1]);
    zero_d = ~(|s1_dlo_q) & ~(|hi_sum);
  end

  // Stage 2 payload registers, loaded only when stage 1 advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (s1_adv) begin
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_carry_lookahead_subtractor_16bit_pipe.sv
// Directed and randomized checks for the two-stage pipelined subtractor.
`timescale 1ns/1ps
module tb_carry_lookahead_subtractor_16bit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_cmp;
  int n_bad;

  carry_lookahead_subtractor_16bit_pipe #(
    .WIDTH (16),
    .LO_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values during and right after reset
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0; b = 16'h0; bin = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, diff, bout, ovf, zero} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h f=%b%b%b want all zero",
               out_valid, diff, bout, ovf, zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  // Single beats with no stall: latency and arithmetic/flags
  task automatic test_vectors();
    logic [15:0] va [7];
    logic [15:0] vb [7];
    logic        vc [7];
    logic [15:0] ed [7];
    logic [2:0]  ef [7];   // {bout, ovf, zero}
    va[0]=16'h1234; vb[0]=16'h0034; vc[0]=1'b0; ed[0]=16'h1200; ef[0]=3'b000;
    va[1]=16'h0000; vb[1]=16'h0001; vc[1]=1'b0; ed[1]=16'hFFFF; ef[1]=3'b100;
    va[2]=16'h0100; vb[2]=16'h0001; vc[2]=1'b1; ed[2]=16'h00FE; ef[2]=3'b000;
    va[3]=16'h8000; vb[3]=16'h0001; vc[3]=1'b0; ed[3]=16'h7FFF; ef[3]=3'b010;
    va[4]=16'h7FFF; vb[4]=16'h7FFE; vc[4]=1'b1; ed[4]=16'h0000; ef[4]=3'b001;
    va[5]=16'h0000; vb[5]=16'hFFFF; vc[5]=1'b1; ed[5]=16'h0000; ef[5]=3'b101;
    va[6]=16'h7FFF; vb[6]=16'h8000; vc[6]=1'b0; ed[6]=16'hFFFF; ef[6]=3'b110;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_early_valid: got %b want 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || diff !== ed[i] || {bout, ovf, zero} !== ef[i]) begin
        n_bad++;
        $display("FAIL vec%0d_result: got v=%b d=%h bof=%b want v=1 d=%h bof=%b",
                 i, out_valid, diff, {bout, ovf, zero}, ed[i], ef[i]);
      end
      @(negedge clk);
    end
  endtask

  // Three beats against a stalled sink, then drain in order at 1/cycle
  task automatic test_backpressure();
    out_ready = 1'b0;
    a = 16'h1000; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; bin = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff !== 16'h0FFF ||
          {bout, ovf, zero} !== 3'b000) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%h bof=%b want 0 1 0fff 000",
                 k, in_ready, out_valid, diff, {bout, ovf, zero});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || diff !== 16'h0001 || {bout, ovf, zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL bp_drain_b: got v=%b d=%h bof=%b want 1 0001 000",
               out_valid, diff, {bout, ovf, zero});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || diff !== 16'hFFFF || {bout, ovf, zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL bp_drain_c: got v=%b d=%h bof=%b want 1 ffff 000",
               out_valid, diff, {bout, ovf, zero});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  // Random stream with random valid/ready; results checked in order
  task automatic test_back_to_back();
    logic [18:0] sb [$];
    logic [18:0] exp_v;
    logic [16:0] t;
    logic [15:0] rd;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    in_valid = 1'b0;
    while ((sent < 2000 || sb.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        if ($urandom_range(0, 7) == 0) b = a;
        in_valid = 1'b1;
      end
      #1;
      if (in_valid && in_ready) begin
        t  = {1'b0, a} - {1'b0, b} - 17'(bin);
        rd = t[15:0];
        sb.push_back({t[16], (a[15] != b[15]) && (rd[15] != a[15]), rd == 16'h0, rd});
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_extra_beat: got d=%h with no pending beat", diff);
        end else begin
          exp_v = sb.pop_front();
          if ({bout, ovf, zero, diff} !== exp_v) begin
            n_bad++;
            $display("FAIL rnd_beat%0d: got bof=%b d=%h want bof=%b d=%h",
                     got, {bout, ovf, zero}, diff, exp_v[18:16], exp_v[15:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (in_valid && sent > 0 && !(sb.size() == 0 && got == 0) ) begin end
      @(negedge clk);
      if (in_valid) begin
        // drop valid only once the held beat was taken
        if (sent > 0 && last_taken(sent)) in_valid = 1'b0;
      end
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20000 || got != 2000) begin
      n_bad++;
      $display("FAIL rnd_completion: got %0d results in %0d cycles want 2000", got, cyc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  // Tracks whether the beat currently on the bus has been counted as sent
  int sent_seen;
  function automatic logic last_taken(input int sent_now);
    logic r;
    r = (sent_now != sent_seen);
    sent_seen = sent_now;
    return r;
  endfunction

  // Asynchronous reset with two beats in flight
  task automatic test_reset_mid();
    out_ready = 1'b0;
    a = 16'h0000; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || diff !== 16'hFFFF || bout !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_loaded: got v=%b d=%h bout=%b want 1 ffff 1",
               out_valid, diff, bout);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, diff, bout, ovf, zero} !== 20'h0) begin
      n_bad++;
      $display("FAIL rm_async_clear: got v=%b d=%h bof=%b want all zero",
               out_valid, diff, {bout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_in_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rm_stale%0d: got out_valid=%b want 0", k, out_valid);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sent_seen = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
